// File: rtl/inv_key_expansion.sv
// Iterative AES-128 inverse key schedule: emits round keys 10 down to 0, one
// per valid/ready transfer, regenerating each previous key from the current one.
module inv_key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] keyIn,
    input  logic         keyReady,
    output logic [127:0] keyOut,
    output logic [3:0]   roundOut,
    output logic         keyValid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t       state_r;
    logic [127:0] key_r;
    logic [3:0]   round_r;
    logic         valid_r;
    logic         busy_r;
    logic         done_r;
    logic [127:0] prev_key_s;
    logic         xfer_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end else begin
                p = p;
            end
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return {c, 24'h000000};
    endfunction

    // Previous round key from the current one; only word 0 needs the S-box.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, p3;
        w0 = key_r[127:96];
        w1 = key_r[95:64];
        w2 = key_r[63:32];
        w3 = key_r[31:0];
        p3 = w3 ^ w2;
        prev_key_s = {w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ rcon(round_r),
                      w1 ^ w0, w2 ^ w1, p3};
    end

    assign xfer_s = valid_r & keyReady;

    // Schedule FSM; all outputs come straight from these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            key_r   <= 128'd0;
            round_r <= 4'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        key_r   <= keyIn;
                        round_r <= 4'd10;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (xfer_s && (round_r == 4'd0)) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else if (xfer_s) begin
                        key_r   <= prev_key_s;
                        round_r <= round_r - 4'd1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign keyOut   = key_r;
    assign roundOut = round_r;
    assign keyValid = valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
